mux_nto1_stream: RTL and testbench

//  - Parametrised N-to-1 stream multiplexer with valid/ready handshake, per-beat arbitration and a registered output.
//  - Generalises the fixed 2/4/8-to-1 combinational muxes to any input count and data width.
//  - Arbitration is either an external select or round-robin.
//  - Sits between N producer streams and one consumer: bus merging, channel funnelling, debug capture.

---
 rtl/mux_nto1_stream_pkg.sv | 17 +
 rtl/mux_nto1_stream_rr_arbiter.sv | 42 ++++
 rtl/mux_nto1_stream.sv | 112 +++++++++++
 tb/tb_mux_nto1_stream.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux_nto1_stream_pkg.sv
// Shared types and helpers for the N-to-1 stream multiplexer.
package mux_pkg;

  typedef enum logic {ARB_SEL, ARB_RR} arb_mode_e;

  // Widest one-hot vector onehot2idx accepts; narrower callers zero-extend.
  localparam int MAX_CH = 256;

  function automatic int onehot2idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++)
      if (oh[i]) idx = idx | i;
    return idx;
  endfunction

endpackage

// File: rtl/mux_nto1_stream_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the granted channel when told to advance.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             adv,
  input  logic [SEL_W-1:0] adv_idx,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic             found;

  // Scan two laps of the request vector so the wrap is handled without modulo on ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * N_CH; i++) begin
      if (i >= int'(ptr) && req[i % N_CH] && !found) begin
        grant[i % N_CH] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign grant_idx = SEL_W'(onehot2idx(MAX_CH'(grant)));

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (adv)
      ptr <= (int'(adv_idx) == N_CH - 1) ? '0 : adv_idx + 1'b1;
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-to-1 valid/ready stream mux with select or round-robin arbitration and a registered output.
// Optional packet lock (grant held until in_last) enabled by defining MUX_STREAM_PKT_LOCK_EN.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter int        N_CH     = 8,
  parameter int        WIDTH    = 2,
  parameter arb_mode_e ARB_MODE = ARB_SEL,
  localparam int       SEL_W    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_last,
  input  logic                  out_ready
);

  logic [N_CH-1:0][WIDTH-1:0] ch_data;
  logic [N_CH-1:0]            sel_grant, rr_grant, grant;
  logic [SEL_W-1:0]           rr_idx, grant_idx;
  logic [WIDTH-1:0]           acc_data;
  logic                       load_en, accept, acc_last, adv;

`ifdef MUX_STREAM_PKT_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign load_en   = !out_valid || out_ready;
  assign sel_grant = (int'(sel_i) < N_CH) ? (N_CH'(1) << sel_i) : '0;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .adv       (adv),
    .adv_idx   (grant_idx),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  always_comb begin
    if (ARB_MODE == ARB_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant     = sel_grant;
      grant_idx = sel_i;
    end
`ifdef MUX_STREAM_PKT_LOCK_EN
    if (locked) begin
      grant     = N_CH'(1) << lock_ch;
      grant_idx = lock_ch;
    end
`endif
  end

  // AND-OR select keeps out-of-range sel_i from indexing past the channel array.
  always_comb begin
    acc_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (grant[k]) acc_data = acc_data | ch_data[k];
  end

  assign acc_last = |(in_last & grant);
  assign in_ready = rst ? '0 : (grant & {N_CH{load_en}});
  assign accept   = |(in_valid & in_ready);

`ifdef MUX_STREAM_PKT_LOCK_EN
  assign adv = accept && acc_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      locked  <= !acc_last;
      lock_ch <= grant_idx;
    end
  end
`else
  assign adv = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= acc_data;
        out_ch   <= grant_idx;
        out_last <= acc_last;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream: select mode (8 and 5 channels) and round-robin mode.
module tb_mux_nto1_stream;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // select-mode, 8 channels
  logic [2:0]  s_sel;
  logic [7:0]  s_valid, s_last, s_in_ready;
  logic [15:0] s_data;
  logic        s_out_valid, s_out_last, s_ordy;
  logic [1:0]  s_out_data;
  logic [2:0]  s_out_ch;

  // round-robin, 8 channels
  logic [2:0]  r_sel;
  logic [7:0]  r_valid, r_last, r_in_ready;
  logic [15:0] r_data;
  logic        r_out_valid, r_out_last, r_ordy;
  logic [1:0]  r_out_data;
  logic [2:0]  r_out_ch;

  // select-mode, 5 channels
  logic [2:0]  f_sel;
  logic [4:0]  f_valid, f_last, f_in_ready;
  logic [9:0]  f_data;
  logic        f_out_valid, f_out_last, f_ordy;
  logic [1:0]  f_out_data;
  logic [2:0]  f_out_ch;

  mux_nto1_stream #(.N_CH(8), .WIDTH(2), .ARB_MODE(ARB_SEL)) dut_sel (
    .clk(clk), .rst(rst), .sel_i(s_sel), .in_valid(s_valid), .in_data(s_data),
    .in_last(s_last), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_ch(s_out_ch), .out_last(s_out_last), .out_ready(s_ordy));

  mux_nto1_stream #(.N_CH(8), .WIDTH(2), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .sel_i(r_sel), .in_valid(r_valid), .in_data(r_data),
    .in_last(r_last), .in_ready(r_in_ready), .out_valid(r_out_valid),
    .out_data(r_out_data), .out_ch(r_out_ch), .out_last(r_out_last), .out_ready(r_ordy));

  mux_nto1_stream #(.N_CH(5), .WIDTH(2), .ARB_MODE(ARB_SEL)) dut_sel5 (
    .clk(clk), .rst(rst), .sel_i(f_sel), .in_valid(f_valid), .in_data(f_data),
    .in_last(f_last), .in_ready(f_in_ready), .out_valid(f_out_valid),
    .out_data(f_out_data), .out_ch(f_out_ch), .out_last(f_out_last), .out_ready(f_ordy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // channel k carries k%4
    rst = 1'b1;
    s_sel = 3'd5; s_valid = 8'hFF; s_last = 8'hFF; s_data = 16'hE4E4; s_ordy = 1'b1;
    r_sel = 3'd0; r_valid = 8'h00; r_last = 8'h00; r_data = 16'hE4E4; r_ordy = 1'b1;
    f_sel = 3'd0; f_valid = 5'h00; f_last = 5'h00; f_data = 10'h0E4; f_ordy = 1'b0;

    tick(); tick(); #1;
    chk("rst_in_ready", s_in_ready, 8'h00);
    chk("rst_out_valid", s_out_valid, 1'b0);
    chk("rst_out_data", s_out_data, 2'd0);
    chk("rst_out_ch", s_out_ch, 3'd0);
    chk("rst_out_last", s_out_last, 1'b0);
    chk("rst_rr_out_valid", r_out_valid, 1'b0);

    // select ch5, then ch2
    tick(); rst = 1'b0; #1;
    chk("sel5_in_ready", s_in_ready, 8'h20);
    tick(); s_sel = 3'd2; #1;
    chk("sel5_out_valid", s_out_valid, 1'b1);
    chk("sel5_out_data", s_out_data, 2'd1);
    chk("sel5_out_ch", s_out_ch, 3'd5);
    chk("sel5_out_last", s_out_last, 1'b1);
    chk("sel2_in_ready", s_in_ready, 8'h04);
    tick(); s_valid = 8'h00; #1;
    chk("sel2_out_data", s_out_data, 2'd2);
    chk("sel2_out_ch", s_out_ch, 3'd2);
    tick(); #1;
    chk("sel_drain_valid", s_out_valid, 1'b0);

    // round-robin over all channels, no bubbles
    r_valid = 8'hFF; r_last = 8'hFF; r_ordy = 1'b1; #1;
    chk("rr_first_in_ready", r_in_ready, 8'h01);
    for (int i = 0; i < 9; i++) begin
      tick(); #1;
      chk("rr_seq_valid", r_out_valid, 1'b1);
      chk("rr_seq_ch", r_out_ch, 32'(i % 8));
    end
    r_valid = 8'h00;
    tick(); #1;
    chk("rr_drain_valid", r_out_valid, 1'b0);

    // ch2/ch6 only, back-pressure holds ch2
    r_valid = 8'h44; #1;
    chk("rr_bp_in_ready", r_in_ready, 8'h04);
    tick(); r_ordy = 1'b0; #1;
    chk("rr_bp_first_ch", r_out_ch, 3'd2);
    chk("rr_bp_stall_ready", r_in_ready, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rr_bp_hold_valid", r_out_valid, 1'b1);
      chk("rr_bp_hold_ch", r_out_ch, 3'd2);
      chk("rr_bp_hold_data", r_out_data, 2'd2);
    end
    r_ordy = 1'b1; #1;
    chk("rr_bp_next_ready", r_in_ready, 8'h40);
    tick(); r_valid = 8'h00; #1;
    chk("rr_bp_next_ch", r_out_ch, 3'd6);
    chk("rr_bp_next_valid", r_out_valid, 1'b1);
    tick(); #1;
    chk("rr_bp_drain", r_out_valid, 1'b0);

    // 5 channels, out-of-range select
    f_sel = 3'd3; f_valid = 5'h1F; f_last = 5'h1F; f_ordy = 1'b0;
    tick(); f_sel = 3'd7; #1;
    chk("sel5ch_pend_ch", f_out_ch, 3'd3);
    chk("sel5ch_pend_data", f_out_data, 2'd3);
    chk("sel5ch_oor_ready", f_in_ready, 5'h00);
    tick(); f_ordy = 1'b1; #1;
    chk("sel5ch_held_valid", f_out_valid, 1'b1);
    chk("sel5ch_oor_ready2", f_in_ready, 5'h00);
    tick(); #1;
    chk("sel5ch_drained", f_out_valid, 1'b0);
    tick(); #1;
    chk("sel5ch_stays_empty", f_out_valid, 1'b0);

    // reset while a beat is stalled
    r_valid = 8'hFF; r_last = 8'hFF; r_ordy = 1'b0;
    tick(); rst = 1'b1; #1;
    chk("midrst_pend_valid", r_out_valid, 1'b1);
    chk("midrst_pend_ch", r_out_ch, 3'd7);
    chk("midrst_in_ready", r_in_ready, 8'h00);
    tick(); rst = 1'b0; r_ordy = 1'b1; #1;
    chk("midrst_out_valid", r_out_valid, 1'b0);
    chk("midrst_out_ch", r_out_ch, 3'd0);
    chk("midrst_first_grant", r_in_ready, 8'h01);
    tick(); r_valid = 8'h00; #1;
    chk("midrst_first_ch", r_out_ch, 3'd0);
    chk("midrst_first_valid", r_out_valid, 1'b1);
    tick();

`ifdef MUX_STREAM_PKT_LOCK_EN
    // pointer at 1: ch1 packet of 3 beats with ch0/ch3 competing
    r_valid = 8'h0B; r_last = 8'h09; #1;
    chk("lock_first_ready", r_in_ready, 8'h02);
    tick(); #1;
    chk("lock_b1_ch", r_out_ch, 3'd1);
    chk("lock_b1_last", r_out_last, 1'b0);
    tick(); r_last = 8'h0B; #1;
    chk("lock_b2_ch", r_out_ch, 3'd1);
    tick(); #1;
    chk("lock_b3_ch", r_out_ch, 3'd1);
    chk("lock_b3_last", r_out_last, 1'b1);
    tick(); #1;
    chk("lock_next_ch3", r_out_ch, 3'd3);
    tick(); r_valid = 8'h00; #1;
    chk("lock_next_ch0", r_out_ch, 3'd0);
    tick();
`else
    // in_last is only carried through to out_last
    r_valid = 8'h02; r_last = 8'h00;
    tick(); r_last = 8'h02; #1;
    chk("last0_ch", r_out_ch, 3'd1);
    chk("last0_out_last", r_out_last, 1'b0);
    tick(); r_valid = 8'h00; #1;
    chk("last1_out_last", r_out_last, 1'b1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
